// File: rtl/axi_r_tap_forwarder_if.sv
// AXI read-data (R) channel bundle. "master" is the side that produces R beats,
// "slave" is the side that consumes them and drives rready.
interface axi_r_tap_forwarder_if #(
   parameter int DATA_WIDTH = 128,
   parameter int ID_WIDTH   = 32,
   parameter int USER_WIDTH = 64
);
   logic [ID_WIDTH-1:0]   rid;
   logic [DATA_WIDTH-1:0] rdata;
   logic [1:0]            rresp;
   logic                  rlast;
   logic [USER_WIDTH-1:0] ruser;
   logic                  rvalid;
   logic                  rready;

   modport master (
      output rid, rdata, rresp, rlast, ruser, rvalid,
      input  rready
   );

   modport slave (
      input  rid, rdata, rresp, rlast, ruser, rvalid,
      output rready
   );
endinterface

// File: rtl/axi_r_tap_forwarder.sv
// R-channel skid slice from downstream (axim) to upstream (axis) that also copies
// every forwarded beat into a tap FIFO streamed out one burst at a time.
module axi_r_tap_forwarder #(
   parameter int DATA_WIDTH = 128,
   parameter int ID_WIDTH   = 32,
   parameter int USER_WIDTH = 64,
   parameter int FIFO_DEPTH = 16
) (
   input  logic                  clk,
   input  logic                  resetn,
   input  logic                  ready,
   output logic                  valid,
   output logic                  in_progress,
   output logic [DATA_WIDTH-1:0] data,
   axi_r_tap_forwarder_if.slave  axim,
   axi_r_tap_forwarder_if.master axis
);

   localparam int BEAT_W = ID_WIDTH + DATA_WIDTH + 2 + 1 + USER_WIDTH;
   localparam int TAP_W  = DATA_WIDTH + 1;
   localparam int AW     = $clog2(FIFO_DEPTH);
   localparam logic [AW:0] FULL_COUNT = (AW+1)'(FIFO_DEPTH);

   typedef enum logic {IDLE, STREAM} state_e;

   logic [BEAT_W-1:0] in_beat;
   logic [BEAT_W-1:0] main_q, main_d, skid_q, skid_d;
   logic              main_valid_q, main_valid_d, skid_valid_q, skid_valid_d;
   logic              rready_q, rready_d;
   logic              accept, drain;

   logic [TAP_W-1:0]  mem_q [FIFO_DEPTH];
   logic [AW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [AW:0]       count_q, count_d;
   logic              fifo_full_q, fifo_full_d;
   logic              fifo_empty, pop;
   logic [TAP_W-1:0]  head;

   state_e            state_q, state_d;

   assign in_beat = {axim.rid, axim.rdata, axim.rresp, axim.rlast, axim.ruser};
   assign {axis.rid, axis.rdata, axis.rresp, axis.rlast, axis.ruser} = main_q;
   assign axis.rvalid = main_valid_q;
   assign axim.rready = rready_q;

   assign accept = axim.rvalid && rready_q;
   assign drain  = main_valid_q && axis.rready;

   assign fifo_empty  = (count_q == '0);
   assign head        = mem_q[rd_ptr_q];
   assign valid       = !fifo_empty;
   assign data        = fifo_empty ? '0 : head[TAP_W-1:1];
   assign pop         = valid && ready;
   assign in_progress = (state_q == STREAM) || valid;

   // Skid never fills while main is empty, so a draining main always takes skid first.
   always_comb begin
      main_d       = main_q;
      main_valid_d = main_valid_q;
      skid_d       = skid_q;
      skid_valid_d = skid_valid_q;
      if (drain || !main_valid_q) begin
         if (skid_valid_q) begin
            main_d       = skid_q;
            main_valid_d = 1'b1;
            skid_valid_d = 1'b0;
         end else if (accept) begin
            main_d       = in_beat;
            main_valid_d = 1'b1;
         end else begin
            main_valid_d = 1'b0;
         end
      end else if (accept) begin
         skid_d       = in_beat;
         skid_valid_d = 1'b1;
      end
   end

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (accept) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop)    rd_ptr_d = rd_ptr_q + AW'(1);
      case ({accept, pop})
         2'b10:   count_d = count_q + (AW+1)'(1);
         2'b01:   count_d = count_q - (AW+1)'(1);
         default: count_d = count_q;
      endcase
      fifo_full_d = (count_d == FULL_COUNT);
      // Registered so it reads 0 in reset and never depends on this cycle's handshakes.
      rready_d    = !skid_valid_d && !fifo_full_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (pop && !head[0]) state_d = STREAM;
         STREAM:  if (pop && head[0])  state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         main_q       <= '0;
         main_valid_q <= 1'b0;
         skid_q       <= '0;
         skid_valid_q <= 1'b0;
         rready_q     <= 1'b0;
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         count_q      <= '0;
         fifo_full_q  <= 1'b0;
         state_q      <= IDLE;
      end else begin
         main_q       <= main_d;
         main_valid_q <= main_valid_d;
         skid_q       <= skid_d;
         skid_valid_q <= skid_valid_d;
         rready_q     <= rready_d;
         wr_ptr_q     <= wr_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         count_q      <= count_d;
         fifo_full_q  <= fifo_full_d;
         state_q      <= state_d;
      end
   end

   // Storage carries no reset; the head is masked off whenever the FIFO is empty.
   always_ff @(posedge clk) begin
      if (accept) mem_q[wr_ptr_q] <= {axim.rdata, axim.rlast};
   end

endmodule

// File: tb/tb_axi_r_tap_forwarder.sv
// Directed bench for axi_r_tap_forwarder: pass-through, stalls, tap back-pressure,
// full boundary, single-beat bursts and reset in mid-burst.
module tb_axi_r_tap_forwarder;

   localparam int DW = 128;
   localparam int IW = 32;
   localparam int UW = 64;
   localparam int FD = 16;

   logic          clk = 1'b0;
   logic          resetn;
   logic          ready;
   logic          valid;
   logic          in_progress;
   logic [DW-1:0] data;

   int compareCount  = 0;
   int mismatchCount = 0;
   int burstBase, burstTotal, sentCount, nextPop, ipDrops;

   axi_r_tap_forwarder_if #(.DATA_WIDTH(DW), .ID_WIDTH(IW), .USER_WIDTH(UW)) axim_if ();
   axi_r_tap_forwarder_if #(.DATA_WIDTH(DW), .ID_WIDTH(IW), .USER_WIDTH(UW)) axis_if ();

   axi_r_tap_forwarder #(
      .DATA_WIDTH(DW), .ID_WIDTH(IW), .USER_WIDTH(UW), .FIFO_DEPTH(FD)
   ) dut (
      .clk(clk), .resetn(resetn), .ready(ready), .valid(valid),
      .in_progress(in_progress), .data(data),
      .axim(axim_if), .axis(axis_if)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [159:0] observed,
                              input logic [159:0] expected);
      compareCount++;
      if (observed !== expected) begin
         mismatchCount++;
         $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
      end
   endtask

   task automatic applyStimulus(input logic rv, input logic [DW-1:0] rd, input logic rl,
                                input logic axisReady, input logic tapReady);
      axim_if.rvalid = rv;
      axim_if.rdata  = rd;
      axim_if.rlast  = rl;
      axis_if.rready = axisReady;
      ready          = tapReady;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic driveBeat(input int idx);
      axim_if.rvalid = 1'b1;
      axim_if.rdata  = DW'(burstBase + idx);
      axim_if.rlast  = (idx == burstTotal - 1);
   endtask

   task automatic startBurst(input int base, input int total);
      burstBase  = base;
      burstTotal = total;
      sentCount  = 0;
      nextPop    = base;
      driveBeat(0);
   endtask

   // One clock of a scored burst: order-check any tap pop, advance the R beat on accept.
   task automatic stepCycle();
      logic accepted;
      accepted = axim_if.rvalid && axim_if.rready;
      if (valid && ready) begin
         checkOutput("tap order", data, DW'(nextPop));
         nextPop++;
      end
      tick();
      if (accepted) sentCount++;
      if (sentCount < burstTotal) driveBeat(sentCount);
      else axim_if.rvalid = 1'b0;
   endtask

   initial begin
      resetn        = 1'b0;
      axim_if.rid   = IW'(5);
      axim_if.rresp = 2'b00;
      axim_if.ruser = '0;
      applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b0);
      #2;
      checkOutput("reset AXIS_rvalid", axis_if.rvalid, 1'b0);
      checkOutput("reset AXIM_rready", axim_if.rready, 1'b0);
      checkOutput("reset valid", valid, 1'b0);
      checkOutput("reset in_progress", in_progress, 1'b0);
      checkOutput("reset data", data, '0);
      checkOutput("reset AXIS_rdata", axis_if.rdata, '0);

      tick();
      tick();
      resetn = 1'b1;
      tick();
      checkOutput("rready after reset", axim_if.rready, 1'b1);

      $display("[TB] basic pass-through");
      for (int i = 0; i < 8; i++) begin
         applyStimulus(1'b1, DW'(i + 1), (i == 7), 1'b1, 1'b1);
         tick();
         checkOutput("pass AXIS_rdata", axis_if.rdata, DW'(i + 1));
         checkOutput("pass AXIS_rlast", axis_if.rlast, (i == 7));
         checkOutput("pass data", data, DW'(i + 1));
         checkOutput("pass in_progress", in_progress, 1'b1);
      end
      checkOutput("pass AXIS_rid", axis_if.rid, 160'd5);
      applyStimulus(1'b0, '0, 1'b0, 1'b1, 1'b1);
      tick();
      checkOutput("pass end AXIS_rvalid", axis_if.rvalid, 1'b0);
      checkOutput("pass end valid", valid, 1'b0);
      checkOutput("pass end in_progress", in_progress, 1'b0);

      $display("[TB] upstream stall");
      applyStimulus(1'b1, DW'('h11), 1'b0, 1'b1, 1'b1);
      tick();
      checkOutput("stall first AXIS_rdata", axis_if.rdata, 160'h11);
      applyStimulus(1'b1, DW'('h12), 1'b0, 1'b0, 1'b1);
      tick();
      checkOutput("stall2 AXIM_rready", axim_if.rready, 1'b0);
      checkOutput("stall2 AXIS_rdata", axis_if.rdata, 160'h11);
      applyStimulus(1'b1, DW'('h13), 1'b0, 1'b0, 1'b1);
      tick();
      checkOutput("stall3 AXIS_rdata", axis_if.rdata, 160'h11);
      checkOutput("stall3 AXIS_rvalid", axis_if.rvalid, 1'b1);
      tick();
      checkOutput("stall underrun valid", valid, 1'b0);
      checkOutput("stall underrun in_progress", in_progress, 1'b1);
      checkOutput("stall AXIM_rready held", axim_if.rready, 1'b0);
      applyStimulus(1'b1, DW'('h13), 1'b0, 1'b1, 1'b1);
      tick();
      checkOutput("resume skid AXIS_rdata", axis_if.rdata, 160'h12);
      checkOutput("resume AXIM_rready", axim_if.rready, 1'b1);
      tick();
      checkOutput("resume AXIS_rdata 13", axis_if.rdata, 160'h13);
      checkOutput("resume AXIS_rvalid", axis_if.rvalid, 1'b1);
      applyStimulus(1'b1, DW'('h14), 1'b1, 1'b1, 1'b1);
      tick();
      checkOutput("resume AXIS_rdata 14", axis_if.rdata, 160'h14);
      checkOutput("resume AXIS_rlast", axis_if.rlast, 1'b1);
      applyStimulus(1'b0, '0, 1'b0, 1'b1, 1'b1);
      tick();
      checkOutput("stall end AXIS_rvalid", axis_if.rvalid, 1'b0);
      checkOutput("stall end in_progress", in_progress, 1'b0);

      $display("[TB] tap back-pressure and full boundary");
      applyStimulus(1'b0, '0, 1'b0, 1'b1, 1'b0);
      ipDrops = 0;
      startBurst(1, 20);
      for (int c = 0; c < 25; c++) stepCycle();
      checkOutput("fill accepted", sentCount, 16);
      checkOutput("fill AXIM_rready", axim_if.rready, 1'b0);
      checkOutput("fill valid", valid, 1'b1);
      checkOutput("fill head data", data, 160'd1);
      checkOutput("fill in_progress", in_progress, 1'b1);
      ready = 1'b1;
      stepCycle();
      ready = 1'b0;
      checkOutput("full pop rready rise", axim_if.rready, 1'b1);
      checkOutput("full pop no push", sentCount, 16);
      stepCycle();
      checkOutput("refill accepted", sentCount, 17);
      checkOutput("refill AXIM_rready", axim_if.rready, 1'b0);
      ready = 1'b1;
      for (int c = 0; c < 60 && nextPop <= 20; c++) begin
         stepCycle();
         if (nextPop <= 20 && !in_progress) ipDrops++;
      end
      checkOutput("drain popped", nextPop, 21);
      checkOutput("drain accepted", sentCount, 20);
      checkOutput("drain in_progress drops", ipDrops, 0);
      checkOutput("drain end in_progress", in_progress, 1'b0);

      $display("[TB] single-beat bursts");
      for (int b = 0; b < 3; b++) begin
         applyStimulus(1'b1, DW'('hA + b), 1'b1, 1'b1, 1'b1);
         tick();
         checkOutput("single data", data, DW'('hA + b));
         checkOutput("single in_progress", in_progress, 1'b1);
         applyStimulus(1'b0, '0, 1'b0, 1'b1, 1'b1);
         tick();
         checkOutput("single gap valid", valid, 1'b0);
         checkOutput("single gap in_progress", in_progress, 1'b0);
      end

      $display("[TB] reset mid-burst");
      applyStimulus(1'b1, DW'('h21), 1'b0, 1'b1, 1'b0);
      tick();
      applyStimulus(1'b1, DW'('h22), 1'b0, 1'b1, 1'b0);
      tick();
      checkOutput("pre-reset valid", valid, 1'b1);
      resetn = 1'b0;
      #1;
      checkOutput("mid reset AXIS_rvalid", axis_if.rvalid, 1'b0);
      checkOutput("mid reset AXIS_rdata", axis_if.rdata, '0);
      checkOutput("mid reset valid", valid, 1'b0);
      checkOutput("mid reset data", data, '0);
      checkOutput("mid reset in_progress", in_progress, 1'b0);
      checkOutput("mid reset AXIM_rready", axim_if.rready, 1'b0);
      applyStimulus(1'b0, '0, 1'b0, 1'b1, 1'b1);
      tick();
      resetn = 1'b1;
      tick();
      checkOutput("post reset valid", valid, 1'b0);
      checkOutput("post reset AXIM_rready", axim_if.rready, 1'b1);
      startBurst('h31, 4);
      for (int c = 0; c < 20 && nextPop < 'h35; c++) stepCycle();
      checkOutput("post reset burst popped", nextPop, 160'h35);
      checkOutput("post reset burst in_progress", in_progress, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
      $finish;
   end

endmodule
